baud_gen_frac: RTL and testbench

Parametrised UART baud/oversample timing generator with a fractional divider, programmable oversampling ratio and receiver phase resynchronisation. It produces an oversample tick, a transmit bit pulse and a mid-bit receive sample pulse. It sits between the APB UART register block, which supplies the configuration, and the TX/RX shift engines. The RX engine drives rx_resync on start-bit detection.

---
 rtl/baud_gen_frac.sv | 146 ++++++++++++++
 tb/tb_baud_gen_frac.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// ---------------------------------------------------------------------------
// baud_gen_frac
//
// UART baud / oversample timing generator with a fractional divider.
//
// A divider counts PCLK cycles up to shadow_int + ext. The fractional
// accumulator adds shadow_frac on each oversample tick. Its carry (ext)
// stretches the next tick period by one PCLK. The result is an average
// tick period of shadow_int + 1 + shadow_frac / 2^FRAC_W PCLK.
//
// Two oversample counters run from the tick:
//   - the TX counter marks bit boundaries;
//   - the RX counter marks mid-bit sample points and is realigned by
//     rx_resync on the start-bit edge.
//
// Ports
//   PCLK            clock
//   PRESETN         asynchronous active-low reset
//   en              generator enable; low holds all counters at 0
//   cfg_load        one-cycle pulse; latches baud_int/baud_frac/osr and
//                   restarts every counter
//   baud_int        integer divisor minus 1
//   baud_frac       fractional divisor numerator
//   osr             oversample ticks per bit minus 1
//   rx_resync       one-cycle pulse; restarts the RX bit phase
//   os_tick         oversample tick, 1 PCLK wide
//   tx_baud_pulse   TX bit boundary, 1 PCLK wide
//   rx_sample_pulse RX mid-bit sample strobe, 1 PCLK wide
//   cfg_valid       a configuration has been loaded since reset
//
// Handshake note: there are no valid/ready pairs here. cfg_load and
// rx_resync are accepted unconditionally in the cycle they are high. The
// pulse outputs are single-cycle strobes and the consumer cannot stall
// them.
// ---------------------------------------------------------------------------
module baud_gen_frac #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR_W  = 5
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [DIV_W-1:0]  baud_int,
  input  logic [FRAC_W-1:0] baud_frac,
  input  logic [OSR_W-1:0]  osr,
  input  logic              rx_resync,
  output logic              os_tick,
  output logic              tx_baud_pulse,
  output logic              rx_sample_pulse,
  output logic              cfg_valid
);

  // Shadow configuration
  logic [DIV_W-1:0]  r_int;
  logic [FRAC_W-1:0] r_frac;
  logic [OSR_W-1:0]  r_osr;
  logic              r_cfg_valid;

  // Divider / accumulator / oversample counters
  logic [DIV_W:0]    r_div_cnt;
  logic [FRAC_W-1:0] r_frac_acc;
  logic              r_ext;
  logic [OSR_W-1:0]  r_tx_cnt;
  logic [OSR_W-1:0]  r_rx_cnt;

  logic              w_run;
  logic [DIV_W:0]    w_limit;
  logic [FRAC_W:0]   w_frac_sum;
  logic [OSR_W-1:0]  w_rx_mid;
  logic              w_tick;
  logic              w_tx_wrap;
  logic              w_rx_wrap;

  assign w_run = en & r_cfg_valid;

  // The limit is one bit wider than the divisor, so an all-ones shadow_int
  // plus an extension cycle does not wrap to a 1-cycle period.
  assign w_limit    = {1'b0, r_int} + {{DIV_W{1'b0}}, r_ext};
  assign w_frac_sum = {1'b0, r_frac_acc} + {1'b0, r_frac};
  assign w_rx_mid   = r_osr >> 1;

  // A cfg_load cycle restarts everything, so any tick it would coincide
  // with is dropped.
  assign w_tick    = w_run & ~cfg_load & (r_div_cnt == w_limit);
  assign w_tx_wrap = (r_tx_cnt == r_osr);
  assign w_rx_wrap = (r_rx_cnt == r_osr);

  assign os_tick         = w_tick;
  assign tx_baud_pulse   = w_tick & w_tx_wrap;
  assign rx_sample_pulse = w_tick & (r_rx_cnt == w_rx_mid) & ~rx_resync;
  assign cfg_valid       = r_cfg_valid;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_int       <= '0;
      r_frac      <= '0;
      r_osr       <= '0;
      r_cfg_valid <= 1'b0;
      r_div_cnt   <= '0;
      r_frac_acc  <= '0;
      r_ext       <= 1'b0;
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
    end else if (cfg_load) begin
      // A load is accepted regardless of en. It also outranks rx_resync
      // and os_tick.
      r_int       <= baud_int;
      r_frac      <= baud_frac;
      r_osr       <= osr;
      r_cfg_valid <= 1'b1;
      r_div_cnt   <= '0;
      r_frac_acc  <= '0;
      r_ext       <= 1'b0;
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
    end else if (!w_run) begin
      // Idle: hold counters at 0 so that the first tick after enable
      // arrives exactly shadow_int + 1 cycles later.
      r_div_cnt  <= '0;
      r_frac_acc <= '0;
      r_ext      <= 1'b0;
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
    end else begin
      if (w_tick) begin
        r_div_cnt  <= '0;
        r_frac_acc <= w_frac_sum[FRAC_W-1:0];
        r_ext      <= w_frac_sum[FRAC_W];
        r_tx_cnt   <= w_tx_wrap ? '0 : r_tx_cnt + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      // A resync wins over a coincident tick; that tick is not counted
      // for RX.
      if (rx_resync) begin
        r_rx_cnt <= '0;
      end else if (w_tick) begin
        r_rx_cnt <= w_rx_wrap ? '0 : r_rx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
module tb_baud_gen_frac;

  localparam int SEL_OS   = 0;
  localparam int SEL_TX   = 1;
  localparam int SEL_RX   = 2;
  localparam int SEL_S_OS = 3;

  // ---------------- clock / reset ----------------
  logic PCLK;
  logic PRESETN;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // main instance (DIV_W = 16)
  logic        en, cfg_load, rx_resync;
  logic [15:0] baud_int;
  logic [3:0]  baud_frac;
  logic [4:0]  osr;
  logic        os_tick, tx_baud_pulse, rx_sample_pulse, cfg_valid;

  // small instance (DIV_W = 4) for the no-wrap limit case
  logic        en_s, cfg_load_s, rx_resync_s;
  logic [3:0]  baud_int_s;
  logic [3:0]  baud_frac_s;
  logic [4:0]  osr_s;
  logic        os_tick_s, tx_baud_pulse_s, rx_sample_pulse_s, cfg_valid_s;

  baud_gen_frac #(.DIV_W(16), .FRAC_W(4), .OSR_W(5)) u_dut (
    .PCLK            (PCLK),
    .PRESETN         (PRESETN),
    .en              (en),
    .cfg_load        (cfg_load),
    .baud_int        (baud_int),
    .baud_frac       (baud_frac),
    .osr             (osr),
    .rx_resync       (rx_resync),
    .os_tick         (os_tick),
    .tx_baud_pulse   (tx_baud_pulse),
    .rx_sample_pulse (rx_sample_pulse),
    .cfg_valid       (cfg_valid)
  );

  baud_gen_frac #(.DIV_W(4), .FRAC_W(4), .OSR_W(5)) u_dut_s (
    .PCLK            (PCLK),
    .PRESETN         (PRESETN),
    .en              (en_s),
    .cfg_load        (cfg_load_s),
    .baud_int        (baud_int_s),
    .baud_frac       (baud_frac_s),
    .osr             (osr_s),
    .rx_resync       (rx_resync_s),
    .os_tick         (os_tick_s),
    .tx_baud_pulse   (tx_baud_pulse_s),
    .rx_sample_pulse (rx_sample_pulse_s),
    .cfg_valid       (cfg_valid_s)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  logic s_os, s_tx, s_rx, s_cfg, s_os_s;
  int   pulse_cnt;
  int   eq_err;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One PCLK: sample at the falling edge, return 1 time unit after the
  // rising edge, where the caller may change inputs.
  task automatic tick_cycle();
    @(negedge PCLK);
    s_os   = os_tick;
    s_tx   = tx_baud_pulse;
    s_rx   = rx_sample_pulse;
    s_cfg  = cfg_valid;
    s_os_s = os_tick_s;
    if (s_os || s_tx || s_rx) pulse_cnt++;
    if ((s_os != s_tx) || (s_os != s_rx)) eq_err++;
    @(posedge PCLK);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  // Wait for the selected strobe (bounded). Returns the number of cycles
  // up to and including the hit, and the number of os ticks in that span.
  task automatic next_event(input int sel, output int n_cyc, output int n_tick);
    logic hit;
    logic ev;
    hit    = 1'b0;
    n_cyc  = 0;
    n_tick = 0;
    for (int i = 0; i < 2000; i++) begin
      tick_cycle();
      n_cyc++;
      if (sel == SEL_S_OS) begin
        if (s_os_s) n_tick++;
      end else if (s_os) begin
        n_tick++;
      end
      case (sel)
        SEL_OS:  ev = s_os;
        SEL_TX:  ev = s_tx;
        SEL_RX:  ev = s_rx;
        default: ev = s_os_s;
      endcase
      if (ev) begin
        hit = 1'b1;
        break;
      end
    end
    check_eq("event_seen", {31'd0, hit}, 32'd1);
  endtask

  // Pop every expected value and compare it with the next measured event.
  task automatic run_sb(input int sel, input logic by_ticks, input string tag);
    int c, t;
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_event(sel, c, t);
      check_eq(tag, by_ticks ? t : c, e);
    end
  endtask

  task automatic load_main(input logic [15:0] i_int, input logic [3:0] i_frac, input logic [4:0] i_osr);
    baud_int  = i_int;
    baud_frac = i_frac;
    osr       = i_osr;
    cfg_load  = 1'b1;
    tick_cycle();
    cfg_load  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main_seq
    int c, t, g1, g2, ones;
    PRESETN = 1'b0;
    en = 0; cfg_load = 0; rx_resync = 0; baud_int = 0; baud_frac = 0; osr = 0;
    en_s = 0; cfg_load_s = 0; rx_resync_s = 0; baud_int_s = 0; baud_frac_s = 0; osr_s = 0;
    pulse_cnt = 0;
    eq_err = 0;
    @(posedge PCLK); #1;
    cycles(2);
    check_eq("rst_os", {31'd0, s_os}, 0);
    check_eq("rst_tx", {31'd0, s_tx}, 0);
    check_eq("rst_rx", {31'd0, s_rx}, 0);
    check_eq("rst_cfg_valid", {31'd0, s_cfg}, 0);
    PRESETN = 1'b1;

    // 1: enabled without any configuration -> silent
    en = 1'b1;
    baud_int = 16'd0;
    pulse_cnt = 0;
    cycles(200);
    check_eq("nocfg_pulses", pulse_cnt, 0);
    check_eq("nocfg_cfg_valid", {31'd0, s_cfg}, 0);

    // 2: int=3 frac=0 osr=15
    en = 1'b0;
    load_main(16'd3, 4'd0, 5'd15);
    tick_cycle();
    check_eq("cfg_valid_set", {31'd0, s_cfg}, 1);
    baud_int = 16'd7;  // live change without load must not matter
    en = 1'b1;
    repeat (5) exp_q.push_back(32'd4);
    run_sb(SEL_OS, 1'b0, "os_period");
    en = 1'b0; tick_cycle(); en = 1'b1;
    exp_q.push_back(32'd64); exp_q.push_back(32'd64);
    run_sb(SEL_TX, 1'b0, "tx_period");
    en = 1'b0; tick_cycle(); en = 1'b1;
    exp_q.push_back(32'd32); exp_q.push_back(32'd64);
    run_sb(SEL_RX, 1'b0, "rx_period");

    // 3: int=3 frac=8 osr=0 -> 4,4,5,4,5,... and all strobes coincide
    en = 1'b0;
    load_main(16'd3, 4'd8, 5'd0);
    en = 1'b1;
    eq_err = 0;
    exp_q.push_back(32'd4); exp_q.push_back(32'd4); exp_q.push_back(32'd5);
    exp_q.push_back(32'd4); exp_q.push_back(32'd5); exp_q.push_back(32'd4);
    run_sb(SEL_OS, 1'b0, "frac_period");
    next_event(SEL_OS, g1, t);
    next_event(SEL_OS, g2, t);
    check_eq("frac_pair_sum", g1 + g2, 9);
    check_eq("osr0_equal", eq_err, 0);

    // 4: rx_resync mid-bit and coincident with a tick
    en = 1'b0;
    load_main(16'd3, 4'd0, 5'd15);
    en = 1'b1;
    for (int i = 0; i < 3; i++) next_event(SEL_OS, c, t);
    tick_cycle();
    rx_resync = 1'b1; tick_cycle(); rx_resync = 1'b0;
    exp_q.push_back(32'd8); exp_q.push_back(32'd16);
    run_sb(SEL_RX, 1'b1, "resync_ticks");
    next_event(SEL_TX, c, t);
    exp_q.push_back(32'd64);
    run_sb(SEL_TX, 1'b0, "tx_after_resync");
    next_event(SEL_OS, c, t);
    cycles(3);
    rx_resync = 1'b1; tick_cycle(); rx_resync = 1'b0;
    check_eq("coinc_tick", {31'd0, s_os}, 1);
    check_eq("coinc_no_rx", {31'd0, s_rx}, 0);
    exp_q.push_back(32'd8); exp_q.push_back(32'd16);
    run_sb(SEL_RX, 1'b1, "coinc_resync_ticks");

    // 5: cfg_load + rx_resync on a would-be tick, then en gaps
    next_event(SEL_OS, c, t);
    cycles(3);
    baud_int = 16'd3;
    cfg_load = 1'b1; rx_resync = 1'b1;
    tick_cycle();
    cfg_load = 1'b0; rx_resync = 1'b0;
    check_eq("load_supp_os", {31'd0, s_os}, 0);
    exp_q.push_back(32'd64); exp_q.push_back(32'd64);
    run_sb(SEL_TX, 1'b0, "tx_after_load");
    cycles(9);
    en = 1'b0;
    pulse_cnt = 0;
    cycles(10);
    check_eq("en_low_pulses", pulse_cnt, 0);
    en = 1'b1;
    exp_q.push_back(32'd4);
    run_sb(SEL_OS, 1'b0, "first_tick_resume");
    cycles(5);
    en = 1'b0; cycles(10); en = 1'b1;
    exp_q.push_back(32'd32);
    run_sb(SEL_RX, 1'b0, "rx_after_resume");

    // 6: DIV_W=4, int=15 frac=15 -> 16,16,17,17,...
    baud_int_s = 4'd15; baud_frac_s = 4'd15; osr_s = 5'd0;
    en_s = 1'b1; cfg_load_s = 1'b1; tick_cycle(); cfg_load_s = 1'b0;
    exp_q.push_back(32'd16); exp_q.push_back(32'd16);
    repeat (4) exp_q.push_back(32'd17);
    run_sb(SEL_S_OS, 1'b0, "wide_limit_period");

    // int=0 frac=0: tick every cycle, then async reset mid-operation
    en = 1'b0;
    load_main(16'd0, 4'd0, 5'd0);
    en = 1'b1;
    ones = 0;
    for (int i = 0; i < 5; i++) begin
      tick_cycle();
      if (s_os) ones++;
    end
    check_eq("int0_every_cycle", ones, 5);
    check_eq("pre_rst_tick", {31'd0, os_tick}, 1);
    #2;
    PRESETN = 1'b0;
    #1;
    check_eq("async_rst_os", {31'd0, os_tick}, 0);
    check_eq("async_rst_tx", {31'd0, tx_baud_pulse}, 0);
    check_eq("async_rst_rx", {31'd0, rx_sample_pulse}, 0);
    check_eq("async_rst_cfg", {31'd0, cfg_valid}, 0);
    check_eq("async_rst_cfg_s", {31'd0, cfg_valid_s}, 0);
    @(posedge PCLK); #1;
    cycles(2);
    PRESETN = 1'b1;
    pulse_cnt = 0;
    cycles(20);
    check_eq("post_rst_pulses", pulse_cnt, 0);
    check_eq("post_rst_cfg_valid", {31'd0, s_cfg}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
